// File: rtl/irq_controller.sv
// Machine-mode interrupt controller: edge-captures three interrupt sources,
// arbitrates them and sequences trap entry, service watchdog and mret return.
module irq_controller #(
  parameter logic [31:0] VEC_BASE    = 32'h0000_0100,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  irq_src,
  input  logic [3:0]  mie,
  input  logic        pipe_idle,
  input  logic [31:0] pc_in,
  input  logic        mret,
  output logic        take_int,
  output logic [31:0] trap_pc,
  output logic [31:0] vector,
  output logic [1:0]  cause,
  output logic        mie_global_we,
  output logic        mie_global_val,
  output logic [2:0]  mip_pend,
  output logic        busy,
  output logic        overrun,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_TRAP    = 3'd2,
    S_SERVICE = 3'd3,
    S_RETURN  = 3'd4
  } state_t;

  localparam logic [15:0] WD_LAST = 16'(WDOG_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_src_q;
  logic [2:0]  r_pend;
  logic [1:0]  r_cause;
  logic [31:0] r_trap_pc;
  logic [15:0] r_wd;
  logic        r_overrun;

  logic [2:0]  w_edge;
  logic [2:0]  w_elig;
  logic [2:0]  w_clr;
  logic [2:0]  w_pend_next;
  logic [1:0]  w_pick;
  logic        w_cause_elig;
  logic [15:0] w_wd_inc;

  assign w_edge       = irq_src & ~r_src_q;
  assign w_elig       = r_pend & mie[2:0] & {3{mie[3]}};
  assign w_cause_elig = |(w_elig & (3'b001 << r_cause));
  // A fresh edge on the source being cleared re-arms it in the same cycle.
  assign w_clr        = (r_state == S_TRAP) ? (3'b001 << r_cause) : 3'b000;
  assign w_pend_next  = (r_pend & ~w_clr) | w_edge;
  assign w_wd_inc     = (r_wd == 16'hFFFF) ? r_wd : r_wd + 16'd1;

  // Priority: external, then software, then timer.
  always_comb begin
    w_pick = 2'd1;
    if (w_elig[2])      w_pick = 2'd2;
    else if (w_elig[0]) w_pick = 2'd0;
  end

  always_comb begin
    w_state_next   = r_state;
    take_int       = 1'b0;
    mie_global_we  = 1'b0;
    mie_global_val = 1'b0;
    busy           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_elig) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (!w_cause_elig) w_state_next = S_IDLE;
        else if (pipe_idle) w_state_next = S_TRAP;
      end
      S_TRAP: begin
        take_int      = 1'b1;
        mie_global_we = 1'b1;
        w_state_next  = S_SERVICE;
      end
      S_SERVICE: begin
        busy = 1'b1;
        if (mret) w_state_next = S_RETURN;
      end
      S_RETURN: begin
        mie_global_we  = 1'b1;
        mie_global_val = 1'b1;
        w_state_next   = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_src_q   <= 3'b000;
      r_pend    <= 3'b000;
      r_cause   <= 2'd0;
      r_trap_pc <= 32'd0;
      r_wd      <= 16'd0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_src_q <= irq_src;
      r_pend  <= w_pend_next;
      if (r_state == S_IDLE && (|w_elig)) r_cause <= w_pick;
      if (r_state == S_TRAP) begin
        r_trap_pc <= pc_in;
        r_wd      <= 16'd0;
      end else if (r_state == S_SERVICE) begin
        r_wd <= w_wd_inc;
      end
      // Flag becomes visible during SERVICE cycle number WDOG_CYCLES.
      if (r_state == S_SERVICE && w_wd_inc == WD_LAST) r_overrun <= 1'b1;
    end
  end

  assign trap_pc     = r_trap_pc;
  assign vector      = VEC_BASE + {28'd0, r_cause, 2'b00};
  assign cause       = r_cause;
  assign mip_pend    = r_pend;
  assign overrun     = r_overrun;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: trap records are queued at stimulus time
// and checked by an independent monitor whenever take_int fires.
module tb_irq_controller;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT    = 3'd1;
  localparam logic [2:0] ST_TRAP    = 3'd2;
  localparam logic [2:0] ST_SERVICE = 3'd3;
  localparam logic [2:0] ST_RETURN  = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  irq_src;
  logic [3:0]  mie;
  logic        pipe_idle;
  logic [31:0] pc_in;
  logic        mret;
  logic        take_int;
  logic [31:0] trap_pc;
  logic [31:0] vector;
  logic [1:0]  cause;
  logic        mie_global_we;
  logic        mie_global_val;
  logic [2:0]  mip_pend;
  logic        busy;
  logic        overrun;
  logic [2:0]  o_dbg_state;

  // Expected trap record: {cause[1:0], vector[31:0], trap_pc[31:0]}
  logic [65:0] exp_q[$];
  int n_total = 0;
  int n_bad   = 0;
  int trap_cnt = 0;
  int we_cnt   = 0;
  int we_snap;
  logic        chk_pc = 1'b0;
  logic [31:0] exp_pc_hold;

  irq_controller #(.VEC_BASE(32'h0000_0100), .WDOG_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .irq_src(irq_src), .mie(mie), .pipe_idle(pipe_idle),
    .pc_in(pc_in), .mret(mret), .take_int(take_int), .trap_pc(trap_pc),
    .vector(vector), .cause(cause), .mie_global_we(mie_global_we),
    .mie_global_val(mie_global_val), .mip_pend(mip_pend), .busy(busy),
    .overrun(overrun), .o_dbg_state(o_dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_trap(input logic [1:0] c, input logic [31:0] v, input logic [31:0] pc);
    exp_q.push_back({c, v, pc});
  endtask

  task automatic pulse_mret();
    mret = 1'b1;
    tick(1);
    mret = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [65:0] e;
    if (chk_pc) begin
      check("trap_pc", trap_pc, exp_pc_hold);
      chk_pc = 1'b0;
    end
    if (take_int === 1'b1) begin
      trap_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_trap", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("cause", {30'd0, cause}, {30'd0, e[65:64]});
        check("vector", vector, e[63:32]);
        check("trap_we", {31'd0, mie_global_we}, 32'd1);
        check("trap_val", {31'd0, mie_global_val}, 32'd0);
        exp_pc_hold = e[31:0];
        chk_pc = 1'b1;
      end
    end
    if (mie_global_we === 1'b1) we_cnt++;
  end

  // Driver
  initial begin
    rst = 1'b0; irq_src = 3'b000; mie = 4'b0000; pipe_idle = 1'b0;
    pc_in = 32'd0; mret = 1'b0;
    tick(2);
    check("rst_state", {29'd0, o_dbg_state}, {29'd0, ST_IDLE});
    check("rst_take_int", {31'd0, take_int}, 32'd0);
    check("rst_we", {31'd0, mie_global_we}, 32'd0);
    check("rst_val", {31'd0, mie_global_val}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_vector", vector, 32'h100);
    check("rst_pend", {29'd0, mip_pend}, 32'd0);
    check("rst_trap_pc", trap_pc, 32'd0);
    rst = 1'b1;
    tick(1);

    // Single timer edge, 3-clock latency
    mie = 4'b1010; pipe_idle = 1'b1; pc_in = 32'h40; irq_src = 3'b010;
    push_trap(2'd1, 32'h104, 32'h40);
    tick(1);
    check("t1_pend", {29'd0, mip_pend}, 32'b010);
    check("t1_idle", {29'd0, o_dbg_state}, {29'd0, ST_IDLE});
    tick(1);
    check("t1_wait", {29'd0, o_dbg_state}, {29'd0, ST_WAIT});
    check("t1_no_early_trap", {31'd0, take_int}, 32'd0);
    tick(1);
    check("t1_take_int", {31'd0, take_int}, 32'd1);
    tick(1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_take_int_off", {31'd0, take_int}, 32'd0);
    check("t1_pend_clr", {29'd0, mip_pend}, 32'd0);
    pulse_mret();
    check("t1_ret_state", {29'd0, o_dbg_state}, {29'd0, ST_RETURN});
    check("t1_ret_we", {31'd0, mie_global_we}, 32'd1);
    check("t1_ret_val", {31'd0, mie_global_val}, 32'd1);
    tick(1);
    check("t1_back_idle", {29'd0, o_dbg_state}, {29'd0, ST_IDLE});
    check("t1_trap_cnt", trap_cnt, 32'd1);
    irq_src = 3'b000;
    tick(1);

    // Simultaneous software + external: external first
    mie = 4'b1111; pc_in = 32'h80; irq_src = 3'b101;
    push_trap(2'd2, 32'h108, 32'h80);
    push_trap(2'd0, 32'h100, 32'h84);
    tick(3);
    check("t2_first_cause", {30'd0, cause}, 32'd2);
    tick(1);
    check("t2_pend_between", {29'd0, mip_pend}, 32'b001);
    pc_in = 32'h84;
    pulse_mret();
    tick(3);
    check("t2_second_trap", {31'd0, take_int}, 32'd1);
    check("t2_second_cause", {30'd0, cause}, 32'd0);
    tick(1);
    check("t2_pend_empty", {29'd0, mip_pend}, 32'd0);
    pulse_mret();
    tick(1);
    check("t2_trap_cnt", trap_cnt, 32'd3);
    irq_src = 3'b000;
    tick(1);

    // Pending timer stalled by pipe_idle=0, then disabled
    mie = 4'b1010; pipe_idle = 1'b0; irq_src = 3'b010;
    tick(5);
    check("t3_wait", {29'd0, o_dbg_state}, {29'd0, ST_WAIT});
    mie = 4'b1000;
    tick(1);
    check("t3_abandon", {29'd0, o_dbg_state}, {29'd0, ST_IDLE});
    check("t3_pend_kept", {29'd0, mip_pend}, 32'b010);
    tick(3);
    check("t3_still_idle", {29'd0, o_dbg_state}, {29'd0, ST_IDLE});
    check("t3_no_trap", trap_cnt, 32'd3);

    // Re-enable: held timer traps; then no mret -> watchdog overrun
    pc_in = 32'hC0; pipe_idle = 1'b1; mie = 4'b1010;
    push_trap(2'd1, 32'h104, 32'hC0);
    tick(3);
    check("t4_svc1_busy", {31'd0, busy}, 32'd1);
    check("t4_svc1_ovr", {31'd0, overrun}, 32'd0);
    tick(6);
    check("t4_svc7_ovr", {31'd0, overrun}, 32'd0);
    tick(1);
    check("t4_svc8_ovr", {31'd0, overrun}, 32'd1);
    pulse_mret();
    check("t4_ret_ovr", {31'd0, overrun}, 32'd1);
    tick(1);
    check("t4_idle_ovr", {31'd0, overrun}, 32'd1);
    irq_src = 3'b000;
    tick(1);

    // Re-edge on the source being cleared in TRAP keeps it pending
    mie = 4'b1010; pc_in = 32'h200; irq_src = 3'b010;
    push_trap(2'd1, 32'h104, 32'h200);
    push_trap(2'd1, 32'h104, 32'h204);
    tick(1);
    irq_src = 3'b000;
    tick(2);
    check("t6_in_trap", {29'd0, o_dbg_state}, {29'd0, ST_TRAP});
    irq_src = 3'b010;
    tick(1);
    check("t6_set_wins", {29'd0, mip_pend}, 32'b010);
    pc_in = 32'h204;
    pulse_mret();
    tick(3);
    check("t6_retrap", {31'd0, take_int}, 32'd1);
    tick(1);
    pulse_mret();
    tick(1);
    irq_src = 3'b000;
    tick(1);

    // Reset during SERVICE
    mie = 4'b1100; pc_in = 32'h300; irq_src = 3'b100;
    push_trap(2'd2, 32'h108, 32'h300);
    tick(4);
    check("t5_busy", {31'd0, busy}, 32'd1);
    irq_src = 3'b101;
    tick(1);
    check("t5_pend_pre", {29'd0, mip_pend}, 32'b001);
    we_snap = we_cnt;
    rst = 1'b0; irq_src = 3'b000;
    tick(1);
    check("t5_busy_off", {31'd0, busy}, 32'd0);
    check("t5_pend_off", {29'd0, mip_pend}, 32'd0);
    check("t5_ovr_off", {31'd0, overrun}, 32'd0);
    check("t5_state", {29'd0, o_dbg_state}, {29'd0, ST_IDLE});
    check("t5_vector", vector, 32'h100);
    check("t5_trap_pc", trap_pc, 32'd0);
    check("t5_we_low", {31'd0, mie_global_we}, 32'd0);
    rst = 1'b1;
    tick(1);
    pulse_mret();
    tick(2);
    check("t5_mret_ignored", {29'd0, o_dbg_state}, {29'd0, ST_IDLE});
    check("t5_busy_after", {31'd0, busy}, 32'd0);
    check("t5_no_we_pulse", we_cnt, we_snap);

    tick(2);
    check("all_traps_seen", exp_q.size(), 32'd0);
    check("trap_total", trap_cnt, 32'd7);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
